// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and constants for the UART/ALU sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_alu_pkg;

  localparam int NBITS_DATA_DEF = 8;
  localparam int NBITS_OP_DEF   = 6;

  // Sequencer states; the encoding is fixed so the state register is 3 bits.
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // ALU opcodes carried in the low bits of the opcode byte.
  localparam logic [NBITS_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NBITS_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NBITS_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NBITS_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NBITS_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NBITS_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NBITS_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NBITS_OP_DEF-1:0] OP_SRL = 6'h02;

  // Only the operand-collection states run the inter-byte timeout.
  function automatic logic is_timed(input state_t s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART RX/TX, baud tick and ALU signals around the sequencer.
// Latency: none (wiring only).
// Backpressure: TX side uses start/done handshake; RX has none (overrun flagged).
interface uart_alu_ctrl_if
  import uart_alu_pkg::*;
#(
  parameter int NBITS_DATA = NBITS_DATA_DEF,
  parameter int NBITS_OP   = NBITS_OP_DEF
) ();

  logic                  i_rx_done;
  logic [NBITS_DATA-1:0] i_rx_data;
  logic                  i_tick_brg;
  logic                  i_tx_done;
  logic [NBITS_DATA-1:0] i_alu_result;
  logic [NBITS_DATA-1:0] o_alu_a;
  logic [NBITS_DATA-1:0] o_alu_b;
  logic [NBITS_OP-1:0]   o_alu_op;
  logic                  o_tx_start;
  logic [NBITS_DATA-1:0] o_tx_data;
  logic                  o_busy;
  logic                  o_timeout;
  logic                  o_overrun;

  // Environment side: UART pair, baud generator and ALU.
  modport master (
    output i_rx_done, i_rx_data, i_tick_brg, i_tx_done, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
    input  o_busy, o_timeout, o_overrun
  );

  // Sequencer side.
  modport slave (
    input  i_rx_done, i_rx_data, i_tick_brg, i_tx_done, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
    output o_busy, o_timeout, o_overrun
  );

endinterface

// File: rtl/uart_alu_ctrl_tick_timeout.sv
// Counts baud ticks while enabled; flags the tick that completes TIMEOUT_TCK.
// Latency: expire is combinational on the terminal tick; count clears next edge.
// Backpressure: none; clr or !en hold the count at zero.
module tick_timeout #(
  parameter int TIMEOUT_TCK = 640
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expire
);

  localparam int CW = (TIMEOUT_TCK > 1) ? $clog2(TIMEOUT_TCK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TCK - 1);

  logic [CW-1:0] count;

  assign expire = en && tick && (count == LAST);

  // Tick counter: parked at zero unless enabled, wraps to zero on the terminal tick.
  always_ff @(posedge i_clk) begin
    if (i_reset || clr || !en) begin
      count <= '0;
    end else if (tick) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from UART RX, runs the ALU, sends the result to UART TX.
// Latency: opcode rx_done at cycle N -> EXEC at N+1 -> tx_start with data at N+2.
// Backpressure: waits for tx_done; bytes arriving in EXEC/SEND/WAIT_TX are dropped with overrun.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NBITS_DATA  = NBITS_DATA_DEF,
  parameter int NBITS_OP    = NBITS_OP_DEF,
  parameter int TIMEOUT_TCK = 640
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_alu_ctrl_if.slave bus
);

  state_t state, state_nxt;
  logic   ld_a, ld_b, ld_op, cap_res;
  logic   timeout_nxt, overrun_nxt, cnt_clr, expire;

  logic [NBITS_DATA-1:0] alu_a, alu_b, tx_data;
  logic [NBITS_OP-1:0]   alu_op;
  logic                  timeout_q, overrun_q;

  tick_timeout #(.TIMEOUT_TCK(TIMEOUT_TCK)) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clr     (cnt_clr),
    .en      (is_timed(state)),
    .tick    (bus.i_tick_brg),
    .expire  (expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_nxt;
  end

  // Next state and datapath strobes; an arriving byte beats an expiring tick.
  always_comb begin
    state_nxt   = state;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_op       = 1'b0;
    cap_res     = 1'b0;
    cnt_clr     = 1'b0;
    timeout_nxt = 1'b0;
    overrun_nxt = 1'b0;
    unique case (state)
      WAIT_A: if (bus.i_rx_done) begin
        ld_a      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_done) begin
        ld_b      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT_OP;
      end else if (expire) begin
        timeout_nxt = 1'b1;
        state_nxt   = WAIT_A;
      end
      WAIT_OP: if (bus.i_rx_done) begin
        ld_op     = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = EXEC;
      end else if (expire) begin
        timeout_nxt = 1'b1;
        state_nxt   = WAIT_A;
      end
      EXEC: begin
        cap_res     = 1'b1;
        overrun_nxt = bus.i_rx_done;
        state_nxt   = SEND;
      end
      SEND: begin
        overrun_nxt = bus.i_rx_done;
        state_nxt   = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_nxt = bus.i_rx_done;
        if (bus.i_tx_done) state_nxt = WAIT_A;
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  // Operand/opcode/result registers hold until overwritten; status pulses last one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ld_a)    alu_a   <= bus.i_rx_data;
      if (ld_b)    alu_b   <= bus.i_rx_data;
      if (ld_op)   alu_op  <= bus.i_rx_data[NBITS_OP-1:0];
      if (cap_res) tx_data <= bus.i_alu_result;
      timeout_q <= timeout_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.o_alu_a    = alu_a;
  assign bus.o_alu_b    = alu_b;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_overrun  = overrun_q;
  assign bus.o_tx_start = (state == SEND);
  assign bus.o_busy     = (state != WAIT_A);

endmodule
